// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and issue sequencer in front of a 1-cycle registered ALU
// Issues one command at a time and only when the result slot is free, since the ALU cannot stall.
module alu_cmd_sequencer #(
   parameter int NUMBITS = 32,
   parameter int DEPTH   = 4,
   parameter int TAGW    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUMBITS-1:0]       in_a,
   input  logic [NUMBITS-1:0]       in_b,
   input  logic [2:0]               in_op,
   input  logic [TAGW-1:0]          in_tag,
   output logic [NUMBITS-1:0]       alu_a,
   output logic [NUMBITS-1:0]       alu_b,
   output logic [2:0]               alu_opcode,
   input  logic [NUMBITS-1:0]       alu_result,
   input  logic                     alu_zero,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUMBITS-1:0]       out_result,
   output logic                     out_zero,
   output logic [TAGW-1:0]          out_tag,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

   state_t               state;
   logic [NUMBITS-1:0]   mem_a   [DEPTH];
   logic [NUMBITS-1:0]   mem_b   [DEPTH];
   logic [2:0]           mem_op  [DEPTH];
   logic [TAGW-1:0]      mem_tag [DEPTH];
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        wr_ptr;
   logic [TAGW-1:0]      tag_reg;
   logic                 push;
   logic                 pop;

   assign in_ready = (count < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   // A pop starts an issue, so it is only allowed when the result slot is free or being freed.
   assign pop      = (count != '0) && ((state == IDLE) || ((state == RESULT) && out_ready));
   assign busy     = (state != IDLE) || (count != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]   <= in_a;
         mem_b[wr_ptr]   <= in_b;
         mem_op[wr_ptr]  <= in_op;
         mem_tag[wr_ptr] <= in_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         tag_reg    <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_zero   <= 1'b0;
         out_tag    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + PW'(1);
            alu_a      <= mem_a[rd_ptr];
            alu_b      <= mem_b[rd_ptr];
            alu_opcode <= mem_op[rd_ptr];
            tag_reg    <= mem_tag[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         case (state)
            IDLE: begin
               if (pop) state <= ISSUE;
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               out_result <= alu_result;
               out_zero   <= alu_zero;
               out_tag    <= tag_reg;
               out_valid  <= 1'b1;
               state      <= RESULT;
            end
            RESULT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= pop ? ISSUE : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
